// File: rtl/bus_cmd_master_if.sv
// Memory-side bus of the byte-command master: address/data/strobes out, read data and busy flags in.
interface bus_cmd_master_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;

  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata, mem_rbusy, mem_wbusy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata, mem_rbusy, mem_wbusy
  );
endinterface

// File: rtl/bus_cmd_master.sv
// Byte-stream command decoder: 'R'/'W' frames become single bus reads/writes, responses are
// returned as bytes on the transmit side. Partial frames are dropped after an idle timeout.
module bus_cmd_master #(
  parameter int unsigned TIMEOUT = 26000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  bus_cmd_master_if.master        mem,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StData, StBusWr, StBusRd, StRdWait, StTxLoad, StTxWait
  } state_e;

  state_e            state_q;
  logic              is_write_q;
  logic [1:0]        byte_cnt_q;
  logic [TmoW-1:0]   tmo_q;
  logic [31:0]       resp_q;
  logic [2:0]        resp_cnt_q;

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      is_write_q    <= 1'b0;
      byte_cnt_q    <= 2'd0;
      tmo_q         <= '0;
      resp_q        <= 32'h0;
      resp_cnt_q    <= 3'd0;
      tx_data       <= 8'h00;
      tx_start      <= 1'b0;
      overrun       <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wdata <= 32'h0;
      mem.mem_wmask <= 4'h0;
      mem.mem_rstrb <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rx_valid) begin
            if (rx_data == 8'h52 || rx_data == 8'h57) begin
              is_write_q <= (rx_data == 8'h57);
              byte_cnt_q <= 2'd0;
              tmo_q      <= '0;
              state_q    <= StAddr;
            end else begin
              resp_q     <= {8'h3F, 24'h0};
              resp_cnt_q <= 3'd1;
              state_q    <= StTxLoad;
            end
          end
        end
        StAddr: begin
          if (rx_valid) begin
            mem.mem_addr <= {mem.mem_addr[23:0], rx_data};
            byte_cnt_q   <= byte_cnt_q + 2'd1;
            tmo_q        <= '0;
            if (byte_cnt_q == 2'd3) begin
              if (is_write_q) begin
                state_q <= StData;
              end else begin
                state_q       <= StBusRd;
                mem.mem_rstrb <= 1'b1;
              end
            end
          end else if (tmo_q == TmoLast) begin
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StData: begin
          if (rx_valid) begin
            mem.mem_wdata <= {mem.mem_wdata[23:0], rx_data};
            byte_cnt_q    <= byte_cnt_q + 2'd1;
            tmo_q         <= '0;
            if (byte_cnt_q == 2'd3) begin
              state_q       <= StBusWr;
              mem.mem_wmask <= 4'hF;
            end
          end else if (tmo_q == TmoLast) begin
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StBusWr: begin
          // First cycle is the strobe itself; completion is judged from the next cycle on.
          if (mem.mem_wmask != 4'h0) begin
            mem.mem_wmask <= 4'h0;
          end else if (!mem.mem_wbusy) begin
            resp_q     <= {8'h4B, 24'h0};
            resp_cnt_q <= 3'd1;
            state_q    <= StTxLoad;
          end
        end
        StBusRd: begin
          mem.mem_rstrb <= 1'b0;
          state_q       <= StRdWait;
        end
        StRdWait: begin
          if (!mem.mem_rbusy) begin
            resp_q     <= mem.mem_rdata;
            resp_cnt_q <= 3'd4;
            state_q    <= StTxLoad;
          end
        end
        StTxLoad: begin
          if (!tx_busy) begin
            tx_data    <= resp_q[31:24];
            resp_q     <= {resp_q[23:0], 8'h00};
            resp_cnt_q <= resp_cnt_q - 3'd1;
            tx_start   <= 1'b1;
            state_q    <= StTxWait;
          end
        end
        StTxWait: begin
          // tx_busy may lag tx_start by a cycle, so the strobe cycle is not trusted.
          if (tx_start) begin
            tx_start <= 1'b0;
          end else if (!tx_busy) begin
            state_q <= (resp_cnt_q != 3'd0) ? StTxLoad : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (rx_valid && (state_q inside {StBusWr, StBusRd, StRdWait, StTxLoad, StTxWait})) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Randomized frame-level bench: a queue model predicts bus accesses, response bytes and
// overruns from the byte stream; a per-cycle monitor compares the DUT against it.
module tb_bus_cmd_master;
  localparam int unsigned TMO = 16;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       overrun;

  bus_cmd_master_if mif ();

  bus_cmd_master #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .mem      (mif),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory contents as seen by reads.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h00430010) return 32'h12345678;
    return (a ^ 32'hA5A5_5A5A) * 32'h0001_0DCD + 32'h1357_9BDF;
  endfunction

  // Model queues.
  logic [63:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  int          exp_ovr = 0;

  // Observations for directed literal checks.
  logic [7:0]  tx_log[$];
  logic [31:0] obs_waddr, obs_wdata;
  int          n_wr = 0, n_rd = 0, ov_seen = 0;
  bit          run_chk = 1'b0;
  int          rd_lat_force = -1;

  // Memory and transmitter responders.
  initial begin : responder
    int wcnt, rcnt, tcnt;
    logic [31:0] raddr;
    wcnt = 0; rcnt = 0; tcnt = 0; raddr = 32'h0;
    mif.mem_wbusy = 1'b0; mif.mem_rbusy = 1'b0; mif.mem_rdata = 32'h0; tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        wcnt = 0; rcnt = 0; tcnt = 0;
        mif.mem_wbusy = 1'b0; mif.mem_rbusy = 1'b0; tx_busy = 1'b0;
      end else begin
        if (mif.mem_wmask != 4'h0) wcnt = $urandom_range(0, 3);
        else if (wcnt > 0) begin mif.mem_wbusy = 1'b1; wcnt--; end
        else mif.mem_wbusy = 1'b0;
        if (mif.mem_rstrb) begin
          rcnt  = (rd_lat_force >= 0) ? rd_lat_force : $urandom_range(0, 4);
          raddr = mif.mem_addr;
        end else if (rcnt > 0) begin mif.mem_rbusy = 1'b1; rcnt--; end
        else mif.mem_rbusy = 1'b0;
        mif.mem_rdata = mif.mem_rbusy ? $urandom : mem_f(raddr);
        if (tx_start) tcnt = $urandom_range(1, 4);
        else if (tcnt > 0) begin tx_busy = 1'b1; tcnt--; end
        else tx_busy = ($urandom_range(0, 7) == 0);
      end
    end
  end

  logic rxv_edge, txb_edge, rst_edge;
  always @(posedge clk) begin
    rxv_edge <= rx_valid;
    txb_edge <= tx_busy;
    rst_edge <= reset;
  end

  // Per-cycle monitor.
  logic [31:0] h_addr, h_data;
  logic [7:0]  h_tx;
  bit          wr_hold = 0, tx_hold = 0, seen_b = 0;
  always @(negedge clk) begin
    if (run_chk && rst_edge) begin
      wr_hold = 0;
      tx_hold = 0;
    end else if (run_chk) begin
      if (mif.mem_wmask != 4'h0 || mif.mem_rstrb)
        chk("wmask_rstrb_excl", 64'((mif.mem_wmask != 4'h0) && mif.mem_rstrb), 64'd0);
      if (mif.mem_wmask != 4'h0) begin
        chk("wmask_value", 64'(mif.mem_wmask), 64'hF);
        chk("write_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          logic [63:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(mif.mem_addr), 64'(e[63:32]));
          chk("wr_data", 64'(mif.mem_wdata), 64'(e[31:0]));
        end
        obs_waddr = mif.mem_addr; obs_wdata = mif.mem_wdata;
        n_wr++;
        wr_hold = 1; h_addr = mif.mem_addr; h_data = mif.mem_wdata;
      end else if (wr_hold) begin
        chk("wr_hold_addr", 64'(mif.mem_addr), 64'(h_addr));
        chk("wr_hold_data", 64'(mif.mem_wdata), 64'(h_data));
        if (!mif.mem_wbusy) wr_hold = 0;
      end
      if (mif.mem_rstrb) begin
        chk("read_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) chk("rd_addr", 64'(mif.mem_addr), 64'(exp_rd.pop_front()));
        n_rd++;
      end
      if (tx_start) begin
        chk("tx_start_while_busy", 64'(txb_edge), 64'd0);
        chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
        if (exp_tx.size() != 0) chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
        tx_log.push_back(tx_data);
        tx_hold = 1; seen_b = 0; h_tx = tx_data;
      end else if (tx_hold) begin
        chk("tx_data_hold", 64'(tx_data), 64'(h_tx));
        if (tx_busy) seen_b = 1;
        else if (seen_b) tx_hold = 0;
      end
      if (overrun) begin
        chk("overrun_cause", 64'(rxv_edge), 64'd1);
        ov_seen++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic gap(input int gmax);
    repeat ($urandom_range(0, gmax)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                            input int gmax);
    if (op == 8'h57) begin
      exp_wr.push_back({a, d});
      exp_tx.push_back(8'h4B);
    end else if (op == 8'h52) begin
      logic [31:0] v;
      v = mem_f(a);
      exp_rd.push_back(a);
      for (int i = 0; i < 4; i++) exp_tx.push_back(v[31-8*i -: 8]);
    end else begin
      exp_tx.push_back(8'h3F);
    end
    send_byte(op);
    if (op == 8'h52 || op == 8'h57) begin
      for (int i = 0; i < 4; i++) begin gap(gmax); send_byte(a[31-8*i -: 8]); end
      if (op == 8'h57)
        for (int i = 0; i < 4; i++) begin gap(gmax); send_byte(d[31-8*i -: 8]); end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"},    64'(mif.mem_addr), 64'd0);
    chk({tag, "_wdata"},   64'(mif.mem_wdata), 64'd0);
    chk({tag, "_wmask"},   64'(mif.mem_wmask), 64'd0);
    chk({tag, "_rstrb"},   64'(mif.mem_rstrb), 64'd0);
    chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    chk({tag, "_tx_start"},64'(tx_start), 64'd0);
    chk({tag, "_busy"},    64'(busy), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    int base_rd, base_wr, base_tx, base_ov, n;
    logic [7:0] op;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;
    run_chk = 1'b1;
    @(negedge clk);

    // Directed write.
    base_wr = n_wr; base_tx = tx_log.size();
    send_frame(8'h57, 32'h00440004, 32'h0000000C, 0);
    wait_idle();
    chk("dir_wr_count", 64'(n_wr - base_wr), 64'd1);
    chk("dir_wr_addr", 64'(obs_waddr), 64'h00440004);
    chk("dir_wr_data", 64'(obs_wdata), 64'h0000000C);
    chk("dir_wr_tx_count", 64'(tx_log.size() - base_tx), 64'd1);
    chk("dir_wr_resp", 64'(tx_log[tx_log.size()-1]), 64'h4B);

    // Directed read with three busy cycles.
    rd_lat_force = 3;
    base_rd = n_rd; base_tx = tx_log.size();
    send_frame(8'h52, 32'h00430010, 32'h0, 0);
    wait_idle();
    rd_lat_force = -1;
    chk("dir_rd_count", 64'(n_rd - base_rd), 64'd1);
    chk("dir_rd_tx_count", 64'(tx_log.size() - base_tx), 64'd4);
    chk("dir_rd_b0", 64'(tx_log[base_tx]),   64'h12);
    chk("dir_rd_b1", 64'(tx_log[base_tx+1]), 64'h34);
    chk("dir_rd_b2", 64'(tx_log[base_tx+2]), 64'h56);
    chk("dir_rd_b3", 64'(tx_log[base_tx+3]), 64'h78);

    // Bad opcode.
    base_rd = n_rd; base_wr = n_wr; base_tx = tx_log.size();
    send_frame(8'h41, 32'h0, 32'h0, 0);
    wait_idle();
    chk("bad_resp", 64'(tx_log[tx_log.size()-1]), 64'h3F);
    chk("bad_tx_count", 64'(tx_log.size() - base_tx), 64'd1);
    chk("bad_no_bus", 64'((n_rd - base_rd) + (n_wr - base_wr)), 64'd0);

    // Timeout on a partial read, boundary at exactly TMO idle cycles.
    base_rd = n_rd; base_tx = tx_log.size();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h40);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_not_early", 64'(busy), 64'd1);
    @(negedge clk);
    chk("tmo_idle", 64'(busy), 64'd0);
    chk("tmo_no_read", 64'(n_rd - base_rd), 64'd0);
    chk("tmo_no_tx", 64'(tx_log.size() - base_tx), 64'd0);
    send_frame(8'h52, 32'h00430010, 32'h0, 2);
    wait_idle();
    chk("tmo_then_read", 64'(n_rd - base_rd), 64'd1);
    chk("tmo_then_b0", 64'(tx_log[tx_log.size()-4]), 64'h12);

    // Overrun during TX_WAIT.
    base_ov = ov_seen;
    send_frame(8'h52, 32'h00001000, 32'h0, 1);
    n = 0;
    while (!tx_start && n < 100) begin @(negedge clk); n++; end
    chk("ovr_saw_tx_start", 64'(tx_start), 64'd1);
    send_byte(8'h57);
    exp_ovr++;
    wait_idle();
    chk("ovr_pulse_once", 64'(ov_seen - base_ov), 64'd1);

    // Randomized traffic.
    for (int f = 0; f < 60; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 7) begin
        if (kind <= 3) op = 8'h57;
        else if (kind <= 6) op = 8'h52;
        else begin
          do op = 8'($urandom); while (op == 8'h52 || op == 8'h57);
        end
        send_frame(op, $urandom, $urandom, 3);
        if ($urandom_range(0, 1) == 1) begin
          gap(3);
          if (busy) begin send_byte(8'($urandom)); exp_ovr++; end
        end
        wait_idle();
      end else begin
        op = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
        n = $urandom_range(0, (op == 8'h57) ? 7 : 3);
        send_byte(op);
        for (int i = 0; i < n; i++) begin gap(3); send_byte(8'($urandom)); end
        repeat (TMO) @(negedge clk);
        chk("rand_tmo_idle", 64'(busy), 64'd0);
      end
    end

    // Reset in the middle of a read.
    rd_lat_force = 10;
    base_rd = n_rd;
    send_frame(8'h52, 32'h00000200, 32'h0, 0);
    n = 0;
    while (n_rd == base_rd && n < 50) begin @(negedge clk); n++; end
    chk("rst_rd_strobe_seen", 64'(n_rd - base_rd), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero_outputs("midrst");
    exp_tx.delete();
    rd_lat_force = -1;
    base_tx = tx_log.size(); base_rd = n_rd;
    repeat (20) @(negedge clk);
    chk("midrst_no_tx", 64'(tx_log.size() - base_tx), 64'd0);
    chk("midrst_no_strobe", 64'(n_rd - base_rd), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);

    chk("end_exp_wr", 64'(exp_wr.size()), 64'd0);
    chk("end_exp_rd", 64'(exp_rd.size()), 64'd0);
    chk("end_exp_tx", 64'(exp_tx.size()), 64'd0);
    chk("end_overruns", 64'(ov_seen), 64'(exp_ovr));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
